// File: rtl/load_arb_pkg.sv
// Shared defaults and state type for the load arbiter and its round-robin picker.
package load_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int NDST_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;
endpackage

// File: rtl/load_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above ptr, wrapping.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   winner
);

  int          sum;
  logic [PW-1:0] idx;

  // Walk offsets from the far end so the nearest eligible index is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum    = 0;
    idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = PW'(sum);
      if (elig[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/load_arbiter.sv
// Round-robin arbiter issuing one registered write per cycle onto a shared
// destination-register bus with a one-hot load enable.
module load_arbiter
  import load_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int W    = W_DEF,
  parameter  int NDST = NDST_DEF,
  localparam int DW   = (NDST > 1) ? $clog2(NDST) : 1,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*W-1:0]  data,
  input  logic [NREQ*DW-1:0] dst,
  input  logic               stall,
  output logic [NREQ-1:0]    ack,
  output logic [W-1:0]       bus_out,
  output logic [NDST-1:0]    ld_en,
  output logic               busy
);

  // state | meaning
  // IDLE  | no transfer on the bus this cycle
  // ISSUE | ack/bus_out/ld_en carry the transfer granted at the last edge

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [W-1:0]    bus_q, bus_d;
  logic [NDST-1:0] ld_q, ld_d;
  logic            busy_q, busy_d;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic            grant;
  logic [DW-1:0]   dst_sel;

  // A requester being acked this cycle is masked so it cannot win twice in a row.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .elig   (req & ~ack_q),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign grant   = pick_valid & ~stall;
  assign dst_sel = dst[pick_idx*DW +: DW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    bus_d   = bus_q;
    ld_d    = '0;
    busy_d  = 1'b0;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   if (!grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (grant) begin
      ack_d  = NREQ'(1) << pick_idx;
      bus_d  = data[pick_idx*W +: W];
      ld_d   = NDST'(1) << dst_sel;
      busy_d = 1'b1;
      ptr_d  = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ack_q   <= '0;
      bus_q   <= '0;
      ld_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      bus_q   <= bus_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign bus_out = bus_q;
  assign ld_en   = ld_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_load_arbiter.sv
// Randomized and directed bench for load_arbiter against a transaction-level model.
module tb_load_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int NDST = 4;
  localparam int DW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*W-1:0]  data = '0;
  logic [NREQ*DW-1:0] dst = '0;
  logic               stall = 1'b0;
  logic [NREQ-1:0]    ack;
  logic [W-1:0]       bus_out;
  logic [NDST-1:0]    ld_en;
  logic               busy;

  int n_chk  = 0;
  int n_pass = 0;

  // model of what the outputs should show in the current cycle
  int              m_ptr;
  logic [NREQ-1:0] m_ack;
  logic [W-1:0]    m_bus;
  logic [NDST-1:0] m_ld;
  logic            m_busy;
  int              ack_cnt;

  load_arbiter #(.NREQ(NREQ), .W(W), .NDST(NDST)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .dst(dst), .stall(stall),
    .ack(ack), .bus_out(bus_out), .ld_en(ld_en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_ack = '0; m_bus = '0; m_ld = '0; m_busy = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".ack"},   32'(ack),     32'(m_ack));
    chk({tag, ".ld_en"}, 32'(ld_en),   32'(m_ld));
    chk({tag, ".bus"},   32'(bus_out), 32'(m_bus));
    chk({tag, ".busy"},  32'(busy),    32'(m_busy));
  endtask

  // One clock: decide the winner from the rules, advance, compare at negedge.
  task automatic cycle(input string tag);
    bit g;
    int w;
    int idx;
    g = 0; w = 0;
    if (!stall) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!g && req[idx] && !m_ack[idx]) begin g = 1; w = idx; end
      end
    end
    @(posedge clk);
    if (g) begin
      m_ack  = '0; m_ack[w] = 1'b1;
      m_bus  = data[w*W +: W];
      m_ld   = '0; m_ld[dst[w*DW +: DW]] = 1'b1;
      m_ptr  = (w + 1) % NREQ;
      m_busy = 1'b1;
    end else begin
      m_ack = '0; m_ld = '0; m_busy = 1'b0;
    end
    @(negedge clk);
    chk_outputs(tag);
    if (m_ack != 0) ack_cnt++;
  endtask

  logic [NREQ-1:0] exp_seq [5];

  initial begin
    model_reset();
    #3;
    chk("rst_hold.ack", 32'(ack), 32'h0);
    chk("rst_hold.ld",  32'(ld_en), 32'h0);
    chk("rst_hold.bus", 32'(bus_out), 32'h0);
    chk("rst_hold.busy", 32'(busy), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // single write to dst 2
    req = 4'b0001; data[0 +: W] = 8'h5A; dst[0 +: DW] = 2'd2;
    cycle("single1");
    chk("single1.ack_c", 32'(ack), 32'h1);
    chk("single1.ld_c",  32'(ld_en), 32'h4);
    chk("single1.bus_c", 32'(bus_out), 32'h5A);
    req = '0;
    cycle("single2");
    chk("single2.ld_c", 32'(ld_en), 32'h0);
    chk("single2.busy_c", 32'(busy), 32'h0);

    // all requesters, all dst 0: strict rotation
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    dst = '0;
    for (int i = 0; i < NREQ; i++) data[i*W +: W] = 8'(8'h10 + i);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle("rot");
      chk("rot.seq", 32'(ack), 32'(exp_seq[i]));
      chk("rot.ld1", 32'(ld_en), 32'h1);
    end

    // stall mid-stream for 3 cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cycle("stall");
    chk("stall.quiet", 32'(ack), 32'h0);
    stall = 1'b0;
    cycle("stall_resume");
    chk("stall.resume", 32'(ack), 32'h2);
    cycle("stall_next");

    // lone requester 2 for 6 cycles: 3 acks
    rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    req = 4'b0100; ack_cnt = 0;
    for (int i = 0; i < 6; i++) cycle("lone");
    chk("lone.acks", 32'(ack_cnt), 32'd3);
    req = '0;
    cycle("lone_end");

    // reset landing on a live transfer to dst 1
    rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    for (int i = 0; i < NREQ; i++) dst[i*DW +: DW] = 2'd1;
    req = 4'b1111;
    cycle("pre_rst");
    chk("pre_rst.ld", 32'(ld_en), 32'h2);
    #1 rst = 1'b1;
    #1;
    chk("midrst.ld",  32'(ld_en), 32'h0);
    chk("midrst.ack", 32'(ack),   32'h0);
    @(negedge clk);
    rst = 1'b0; model_reset();
    req = 4'b1001;
    cycle("post_rst");
    chk("post_rst.first", 32'(ack), 32'h1);

    // randomized traffic
    rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && m_ack[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          data[i*W +: W]   = 8'($urandom);
          dst[i*DW +: DW]  = 2'($urandom);
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
